// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_pkg
// Description : Shared constants and types for the buffered 1-to-4 stream
//               demultiplexer. NUM_OUT is the number of output streams and
//               SEL_W is the width of the per-word output select.
// Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

    localparam int NUM_OUT = 4;
    localparam int SEL_W   = 2;

    typedef logic [SEL_W-1:0] sel_t;

endpackage : demux_pkg
`default_nettype wire

// File: rtl/demux_fifo.sv
`default_nettype none
// ============================================================================
// Module      : demux_fifo
// Description : Single-clock first-word-fall-through FIFO used for one
//               output lane of the demultiplexer.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data at the tail (ignored while full)
//   push_data   : word to write
//   pop         : remove the head word (ignored while empty)
//   head_data   : current head word, '0 while empty
//   empty, full : registered occupancy flags
//   count       : number of words held, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module demux_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          head_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH+1);
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr_q;
    logic [c_PTR_W-1:0] r_wr_ptr_q;
    logic [c_CNT_W-1:0] r_count_q;

    logic [c_PTR_W-1:0] w_rd_ptr_d;
    logic [c_PTR_W-1:0] w_wr_ptr_d;
    logic [c_CNT_W-1:0] w_count_d;
    logic               w_do_push;
    logic               w_do_pop;

    assign empty = (r_count_q == '0);
    assign full  = (r_count_q == c_FULL_CNT);

    // A full FIFO refuses the push even when a pop frees a slot this cycle,
    // so acceptance never depends on the consumer's ready.
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Power-of-two depth: pointers wrap naturally at the top of their range.
    always_comb begin
        w_rd_ptr_d = r_rd_ptr_q;
        w_wr_ptr_d = r_wr_ptr_q;
        w_count_d  = r_count_q;
        if (w_do_push) begin
            w_wr_ptr_d = r_wr_ptr_q + c_PTR_W'(1);
        end
        if (w_do_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + c_PTR_W'(1);
        end
        w_count_d = r_count_q + c_CNT_W'(w_do_push) - c_CNT_W'(w_do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr_q <= '0;
            r_wr_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_rd_ptr_q <= w_rd_ptr_d;
            r_wr_ptr_q <= w_wr_ptr_d;
            r_count_q  <= w_count_d;
        end
    end

    // Storage needs no reset: stale entries are never visible because the
    // head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr_q] <= push_data;
        end
    end

    assign head_data = empty ? '0 : r_mem[r_rd_ptr_q];
    assign count     = r_count_q;

endmodule : demux_fifo
`default_nettype wire

// File: rtl/demux1_4_buffered.sv
`default_nettype none
// ============================================================================
// Module      : demux1_4_buffered
// Description : Buffered 1-to-4 valid/ready stream demultiplexer. Each input
//               word is routed by in_sel into one of four FIFOs, each drained
//               by its own independent valid/ready output stream.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_data/in_sel       : word and its target output
//   in_valid/in_ready    : input handshake; in_ready = target FIFO not full
//   out_data[i]          : head word of FIFO i ('0 when empty)
//   out_valid/out_ready  : per-output handshake
//   out_count[i]         : occupancy of FIFO i
// Revision    : 1.0 - initial release
// ============================================================================
module demux1_4_buffered
    import demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [DATA_W-1:0]                         in_data,
    input  logic [SEL_W-1:0]                          in_sel,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    output logic [NUM_OUT-1:0][DATA_W-1:0]            out_data,
    output logic [NUM_OUT-1:0]                        out_valid,
    input  logic [NUM_OUT-1:0]                        out_ready,
    output logic [NUM_OUT-1:0][$clog2(DEPTH+1)-1:0]   out_count
);

    logic [NUM_OUT-1:0] w_full;
    logic [NUM_OUT-1:0] w_empty;
    logic [NUM_OUT-1:0] w_push;
    logic               w_accept;

    // Readiness depends only on the selected lane, so it is meaningful
    // before the producer raises in_valid.
    assign in_ready = !w_full[in_sel];
    assign w_accept = in_valid && in_ready;

    generate
        for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_lane
            assign w_push[gi] = w_accept && (in_sel == sel_t'(gi));

            demux_fifo #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH)
            ) u_fifo (
                .clk       (clk),
                .rst_n     (rst_n),
                .push      (w_push[gi]),
                .push_data (in_data),
                .pop       (out_ready[gi]),
                .head_data (out_data[gi]),
                .empty     (w_empty[gi]),
                .full      (w_full[gi]),
                .count     (out_count[gi])
            );

            assign out_valid[gi] = !w_empty[gi];
        end
    endgenerate

endmodule : demux1_4_buffered
`default_nettype wire
